regfile_alu_datapath: RTL and testbench
=======================================

// Module: regfile_alu_datapath
// PURPOSE
//  Execute-stage datapath core: a 32x32-bit register file (2 async read ports, 1 sync write
//  port) whose two read outputs feed a combinational 32-bit MIPS-style ALU. The processor
//  top level supplies register addresses, write data/enable and the 4-bit ALU opcode. It
//  registers DataOut externally and writes it back through writeData.
// PARAMETERS
//  DATA_W   32  register/ALU data width
//  ADDR_W   5   register address width (2**ADDR_W = 32 registers)
// PORTS
//  clk           in   1       single clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high reset
//  readAddress0  in   5       register index for operand A
//  readAddress1  in   5       register index for operand B
//  writeAddress  in   5       register index written when writeEnable=1
//  writeData     in   32      data written at rising clk edge
//  writeEnable   in   1       1 = write writeData to writeAddress at clk edge
//  ALUControl    in   4       ALU operation select (encodings below)
//  readData0     out  32      contents of readAddress0 (combinational)
//  readData1     out  32      contents of readAddress1 (combinational)
//  DataOut       out  32      ALU result, A=readData0, B=readData1 (combinational)
//  ZeroOut       out  1       1 when DataOut == 32'h0
// BEHAVIOUR
//  - Reset: on a rising clk with reset=1, all 32 registers clear to 0; reset overrides any
//    write in that cycle. Outputs then read 0, so DataOut=0 for ADD and ZeroOut=1.
//  - Write: on a rising clk with reset=0 and writeEnable=1, reg[writeAddress] <= writeData.
//    Latency is 1 cycle: the new value is visible on readDataN after the edge.
//  - Register 0 is hardwired: it always reads 32'h0 and writes to it are ignored.
//  - Read: fully combinational from the addresses and current state. No write-to-read
//    bypass: same-cycle read of the address being written returns the old value.
//  - Both read ports may address the same register; both return identical data.
//  - ALU ops (others -> DataOut=0):
//    0000 AND; 0001 OR; 0010 ADD (A+B, mod 2**32); 0110 SUB (A-B, mod 2**32);
//    0111 SLT (signed A<B ? 1 : 0); 1100 NOR (~(A|B)).
//  - ADD/SUB wrap silently. No overflow or carry output.
//  - SLT compares two's-complement values: 32'h8000_0000 < 32'h0000_0001.
//  - ZeroOut is derived from the selected result, including the default-0 case.
//  - No internal pipeline registers other than the register array; no X on any output
//    after the first reset.
// STRUCTURE
//  - Shared package regfile_alu_pkg holds:
//    ALU opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
//    DATA_W and ADDR_W.
//  - One sub-module, alu_core: purely combinational (A, B, ALUControl -> DataOut, ZeroOut).
//  - The register array and read/write logic live in the top module.
// TESTING
//  1. Reset: reset=1 for one edge after writes to r5 and r9 -> readData0/1 = 0 for all
//     addresses; ADD gives DataOut=0, ZeroOut=1.
//  2. Write/read/add: write r1=32'd7, r2=32'd5, then read 1,2 with ALUControl=0010 ->
//     DataOut=12, ZeroOut=0. With 0110 -> DataOut=2. With 0111 -> 0.
//  3. Same-cycle read/write: read r3 while writing r3=32'hDEAD_BEEF -> old value before the
//     edge, DEAD_BEEF after. Write r0=32'hFFFF_FFFF -> r0 still reads 0.
//  4. Logic/wrap: r1=32'hFFFF_FFFF, r2=32'h1.
//     ADD -> 0, ZeroOut=1. AND -> 1. OR -> FFFF_FFFF. NOR -> 0. SLT -> 1.
//  5. writeEnable=0 with writeAddress=4, writeData=32'h1234 -> r4 unchanged.
//     Reset asserted with writeEnable=1 -> register stays 0.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// Shared constants for the register-file / ALU execute datapath.
//   DATA_W   : register and ALU data width
//   ADDR_W   : register index width
//   NUM_REGS : number of architectural registers
//   ALU_*    : 4-bit ALU operation encodings
package regfile_alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage : regfile_alu_pkg

// File: rtl/regfile_alu_datapath_alu_core.sv
// Combinational MIPS-style ALU.
//   a, b        : operands
//   alu_control : operation select (ALU_* encodings); unknown codes give 0
//   result      : operation result (ADD/SUB wrap modulo 2**DATA_W)
//   zero        : 1 when result is all zeros
module alu_core
  import regfile_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Operation select; default keeps unused encodings at a defined zero.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule : alu_core

// File: rtl/regfile_alu_datapath.sv
// Execute-stage datapath: 32x32 register file (2 async read, 1 sync write)
// feeding a combinational ALU.
//   clk, reset                 : clock, synchronous active-high reset (clears all regs)
//   readAddress0/1             : operand A/B register indices
//   writeAddress/Data/Enable   : write port, committed on rising clk
//   ALUControl                 : ALU operation select
//   readData0/1                : combinational register contents (r0 reads 0)
//   DataOut, ZeroOut           : combinational ALU result and zero flag
module regfile_alu_datapath
  import regfile_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAddress0,
  input  logic [ADDR_W-1:0] readAddress1,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEnable,
  input  logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] readData0,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] DataOut,
  output logic              ZeroOut
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register array; reset wins over a same-cycle write, r0 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
    end else if (writeEnable && (writeAddress != '0)) begin
      regs[writeAddress] <= writeData;
    end
  end

  // Reads see pre-edge state (no write bypass); r0 forced to zero.
  assign readData0 = (readAddress0 == '0) ? '0 : regs[readAddress0];
  assign readData1 = (readAddress1 == '0) ? '0 : regs[readAddress1];

  alu_core u_alu_core (
    .a           (readData0),
    .b           (readData1),
    .alu_control (ALUControl),
    .result      (DataOut),
    .zero        (ZeroOut)
  );

endmodule : regfile_alu_datapath

// File: tb/tb_regfile_alu_datapath.sv
module tb_regfile_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readAddress0, readAddress1, writeAddress;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [3:0]  ALUControl;
  logic [31:0] readData0, readData1, DataOut;
  logic        ZeroOut;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_regs [32];

  regfile_alu_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .readAddress0 (readAddress0),
    .readAddress1 (readAddress1),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .writeEnable  (writeEnable),
    .ALUControl   (ALUControl),
    .readData0    (readData0),
    .readData1    (readData1),
    .DataOut      (DataOut),
    .ZeroOut      (ZeroOut)
  );

  always #5 clk = ~clk;

  // Reference ALU from the opcode table using plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    longint sa, sb;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      4'd6:    return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    writeAddress = addr;
    writeData    = data;
    writeEnable  = 1'b1;
    tick();
    writeEnable  = 1'b0;
    if (addr != 5'd0) model_regs[addr] = data;
  endtask

  task automatic check_outputs(input string name);
    logic [31:0] a, b, r;
    a = model_regs[readAddress0];
    b = model_regs[readAddress1];
    r = ref_alu(a, b, ALUControl);
    #1;
    check({name, ".rd0"}, readData0, a);
    check({name, ".rd1"}, readData1, b);
    check({name, ".dout"}, DataOut, r);
    check({name, ".zero"}, 32'(ZeroOut), (r == 32'd0) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  op;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{"add_7_5",    32'd7,          32'd5,        4'b0010, 32'd12,         1'b0};
    vecs[1]  = '{"sub_7_5",    32'd7,          32'd5,        4'b0110, 32'd2,          1'b0};
    vecs[2]  = '{"slt_7_5",    32'd7,          32'd5,        4'b0111, 32'd0,          1'b1};
    vecs[3]  = '{"and_7_5",    32'd7,          32'd5,        4'b0000, 32'd5,          1'b0};
    vecs[4]  = '{"or_7_5",     32'd7,          32'd5,        4'b0001, 32'd7,          1'b0};
    vecs[5]  = '{"nor_7_5",    32'd7,          32'd5,        4'b1100, 32'hFFFF_FFF8,  1'b0};
    vecs[6]  = '{"add_wrap",   32'hFFFF_FFFF,  32'h1,        4'b0010, 32'd0,          1'b1};
    vecs[7]  = '{"and_m1_1",   32'hFFFF_FFFF,  32'h1,        4'b0000, 32'd1,          1'b0};
    vecs[8]  = '{"or_m1_1",    32'hFFFF_FFFF,  32'h1,        4'b0001, 32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{"nor_m1_1",   32'hFFFF_FFFF,  32'h1,        4'b1100, 32'd0,          1'b1};
    vecs[10] = '{"slt_m1_1",   32'hFFFF_FFFF,  32'h1,        4'b0111, 32'd1,          1'b0};
    vecs[11] = '{"slt_min_1",  32'h8000_0000,  32'h1,        4'b0111, 32'd1,          1'b0};
    vecs[12] = '{"sub_wrap",   32'd0,          32'd1,        4'b0110, 32'hFFFF_FFFF,  1'b0};
    vecs[13] = '{"bad_op",     32'd7,          32'd5,        4'b0011, 32'd0,          1'b1};

    reset = 1'b0; writeEnable = 1'b0; writeAddress = '0; writeData = '0;
    readAddress0 = '0; readAddress1 = '0; ALUControl = 4'b0010;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    // Reset after writes, with a write to r7 pending in the reset cycle.
    write_reg(5'd5, 32'hAAAA_5555);
    write_reg(5'd9, 32'h1357_9BDF);
    reset = 1'b1; writeEnable = 1'b1; writeAddress = 5'd7; writeData = 32'hCAFE_F00D;
    tick();
    reset = 1'b0; writeEnable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readAddress0 = 5'(i); readAddress1 = 5'(31 - i);
      #1;
      check("reset.rd0", readData0, 32'd0);
      check("reset.rd1", readData1, 32'd0);
    end
    readAddress0 = 5'd5; readAddress1 = 5'd7; ALUControl = 4'b0010;
    #1;
    check("reset.add_dout", DataOut, 32'd0);
    check("reset.add_zero", 32'(ZeroOut), 32'd1);

    // Table-driven ALU vectors via r1/r2.
    foreach (vecs[k]) begin
      write_reg(5'd1, vecs[k].v1);
      write_reg(5'd2, vecs[k].v2);
      readAddress0 = 5'd1; readAddress1 = 5'd2; ALUControl = vecs[k].op;
      #1;
      check({vecs[k].name, ".dout"}, DataOut, vecs[k].exp_out);
      check({vecs[k].name, ".zero"}, 32'(ZeroOut), 32'(vecs[k].exp_zero));
    end

    // Same-cycle read of the address being written returns the old value.
    write_reg(5'd3, 32'h0000_0011);
    readAddress0 = 5'd3; readAddress1 = 5'd3;
    writeAddress = 5'd3; writeData = 32'hDEAD_BEEF; writeEnable = 1'b1;
    #1;
    check("rw.before", readData0, 32'h0000_0011);
    tick();
    writeEnable = 1'b0;
    check("rw.after0", readData0, 32'hDEAD_BEEF);
    check("rw.after1", readData1, 32'hDEAD_BEEF);
    model_regs[3] = 32'hDEAD_BEEF;

    // r0 ignores writes.
    write_reg(5'd0, 32'hFFFF_FFFF);
    readAddress0 = 5'd0; readAddress1 = 5'd0; ALUControl = 4'b0001;
    #1;
    check("r0.rd0", readData0, 32'd0);
    check("r0.rd1", readData1, 32'd0);
    check("r0.or_zero", 32'(ZeroOut), 32'd1);

    // writeEnable low leaves the target untouched.
    write_reg(5'd4, 32'h0000_0055);
    writeAddress = 5'd4; writeData = 32'h0000_1234; writeEnable = 1'b0;
    tick();
    readAddress0 = 5'd4;
    #1;
    check("we0.r4", readData0, 32'h0000_0055);

    // Reset beats a write to a register that held data.
    write_reg(5'd6, 32'h0000_0ABC);
    reset = 1'b1; writeEnable = 1'b1; writeAddress = 5'd6; writeData = 32'h1111_2222;
    tick();
    reset = 1'b0; writeEnable = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    readAddress0 = 5'd6; readAddress1 = 5'd4;
    #1;
    check("rst_wr.r6", readData0, 32'd0);
    check("rst_wr.r4", readData1, 32'd0);

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ops [8];
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
      readAddress0 = 5'($urandom_range(0, 31));
      readAddress1 = 5'($urandom_range(0, 31));
      ALUControl   = ops[$urandom_range(0, 7)];
      writeAddress = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       writeData = 32'h8000_0000 | 32'($urandom_range(0, 3));
        1:       writeData = 32'($urandom_range(0, 8));
        default: writeData = $urandom;
      endcase
      writeEnable  = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 49) == 0);
      check_outputs("rand");
      tick();
      if (reset) begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      end else if (writeEnable && writeAddress != 5'd0) begin
        model_regs[writeAddress] = writeData;
      end
      reset = 1'b0;
      writeEnable = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_regfile_alu_datapath
